// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the mips pipeline stages (IF/MA), the memory port arbiter
// and the external memory. master = arbiter side, slave = pipeline/memory side.
interface mem_port_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   localparam int BE_W = DATA_WIDTH / 8;

   logic                  i_if_req;
   logic [ADDR_WIDTH-1:0] i_if_addr;
   logic                  o_if_ack;
   logic                  o_if_err;
   logic [DATA_WIDTH-1:0] o_if_rdata;
   logic                  o_if_stall;

   logic                  i_dm_req;
   logic                  i_dm_we;
   logic [BE_W-1:0]       i_dm_be;
   logic [ADDR_WIDTH-1:0] i_dm_addr;
   logic [DATA_WIDTH-1:0] i_dm_wdata;
   logic                  o_dm_ack;
   logic                  o_dm_err;
   logic [DATA_WIDTH-1:0] o_dm_rdata;
   logic                  o_dm_stall;

   logic                  o_mem_req;
   logic                  o_mem_we;
   logic [BE_W-1:0]       o_mem_be;
   logic [ADDR_WIDTH-1:0] o_mem_addr;
   logic [DATA_WIDTH-1:0] o_mem_wdata;
   logic                  i_mem_ack;
   logic [DATA_WIDTH-1:0] i_mem_rdata;

   modport master (
      input  i_if_req, i_if_addr,
      output o_if_ack, o_if_err, o_if_rdata, o_if_stall,
      input  i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
      output o_dm_ack, o_dm_err, o_dm_rdata, o_dm_stall,
      output o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      input  i_mem_ack, i_mem_rdata
   );

   modport slave (
      output i_if_req, i_if_addr,
      input  o_if_ack, o_if_err, o_if_rdata, o_if_stall,
      output i_dm_req, i_dm_we, i_dm_be, i_dm_addr, i_dm_wdata,
      input  o_dm_ack, o_dm_err, o_dm_rdata, o_dm_stall,
      input  o_mem_req, o_mem_we, o_mem_be, o_mem_addr, o_mem_wdata,
      output i_mem_ack, i_mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and data access, one
// transaction at a time, with a no-ack watchdog. Define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic               i_clk,
   input  logic               i_rst,
   mem_port_arbiter_if.master bus
);
   localparam int BE_W = DATA_WIDTH / 8;
   localparam int CW   = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   typedef struct packed {
      logic                  we;
      logic [BE_W-1:0]       be;
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] wdata;
   } txn_t;

   state_t                state, state_nxt;
   txn_t                  txn_q, grant_txn;
   logic                  owner_dm;
   logic                  err_q;
   logic [CW-1:0]         wd_q;
   logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q, resp_data;
   logic                  any_req, grant_dm, timeout, busy_done;

   assign any_req = bus.i_if_req | bus.i_dm_req;

`ifdef MEM_ARB_RR_EN
   logic last_dm;

   // On contention, hand the port to whichever side did not get it last.
   assign grant_dm = bus.i_dm_req & (~bus.i_if_req | ~last_dm);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)                      last_dm <= 1'b0;
      else if (state == IDLE && any_req) last_dm <= grant_dm;
   end
`else
   // Data access belongs to the older instruction, so it always wins.
   assign grant_dm = bus.i_dm_req;
`endif

   always_comb begin
      if (grant_dm)
         grant_txn = '{we: bus.i_dm_we, be: bus.i_dm_be, addr: bus.i_dm_addr, wdata: bus.i_dm_wdata};
      else
         grant_txn = '{we: 1'b0, be: '1, addr: bus.i_if_addr, wdata: '0};
   end

   // An ack in the last watchdog cycle still counts as a good completion.
   assign timeout   = (wd_q == WD_LAST) & ~bus.i_mem_ack;
   assign busy_done = bus.i_mem_ack | timeout;
   assign resp_data = (bus.i_mem_ack & ~txn_q.we) ? bus.i_mem_rdata : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req)   state_nxt = BUSY;
         BUSY:    if (busy_done) state_nxt = RESP;
         RESP:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         txn_q      <= '0;
         owner_dm   <= 1'b0;
         err_q      <= 1'b0;
         wd_q       <= '0;
         if_rdata_q <= '0;
         dm_rdata_q <= '0;
      end else begin
         case (state)
            IDLE: if (any_req) begin
               txn_q    <= grant_txn;
               owner_dm <= grant_dm;
               err_q    <= 1'b0;
               wd_q     <= '0;
            end
            BUSY: if (busy_done) begin
               err_q <= ~bus.i_mem_ack;
               if (owner_dm) dm_rdata_q <= resp_data;
               else          if_rdata_q <= resp_data;
            end else begin
               wd_q <= wd_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.o_mem_req   = (state == BUSY);
      bus.o_mem_we    = txn_q.we;
      bus.o_mem_be    = txn_q.be;
      bus.o_mem_addr  = txn_q.addr;
      bus.o_mem_wdata = txn_q.wdata;
      bus.o_if_ack    = (state == RESP) & ~owner_dm;
      bus.o_dm_ack    = (state == RESP) &  owner_dm;
      bus.o_if_err    = bus.o_if_ack & err_q;
      bus.o_dm_err    = bus.o_dm_ack & err_q;
      bus.o_if_rdata  = if_rdata_q;
      bus.o_dm_rdata  = dm_rdata_q;
      bus.o_if_stall  = bus.i_if_req & ~bus.o_if_ack;
      bus.o_dm_stall  = bus.i_dm_req & ~bus.o_dm_ack;
   end
endmodule
